sdvm_stream: RTL

Streaming, parametrised signed-digit × vector multiplier for the online divider datapath. Latches a redundant (plus/minus rail) vector operand, then accepts a stream of NDIGITS signed digits under valid/ready handshake and emits one registered product vector per digit, tagging the last. Sits between the quotient-digit selection logic and the residual adder in each Newton/online iteration, replacing the single-cycle combinational selector.

---
 rtl/sdvm_pkg.sv | 17 +
 rtl/sdvm_digit_mul.sv | 43 ++++
 rtl/sdvm_stream.sv | 119 +++++++++++
 3 files changed

// File: rtl/sdvm_pkg.sv
// Shared encodings for the signed-digit vector multiplier and the residual-update path.
// Digit codes follow the quotient-selection output format; NEG_* select the negation rule.
package sdvm_pkg;

   localparam logic [1:0] DIG_ZERO = 2'b00;
   localparam logic [1:0] DIG_POS  = 2'b10;
   localparam logic [1:0] DIG_NEG  = 2'b01;
   localparam logic [1:0] DIG_ILL  = 2'b11;

   localparam int NEG_SWAP = 0;
   localparam int NEG_CMPL = 1;

   function automatic logic dig_is_ill(input logic [1:0] dig);
      return dig == DIG_ILL;
   endfunction

endpackage

// File: rtl/sdvm_digit_mul.sv
// Signed digit times redundant vector: combinational, zero latency, no flow control.
// Illegal digit yields an all-zero product and raises ill.
module sdvm_digit_mul
   import sdvm_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int NEG_MODE = NEG_SWAP
) (
   input  logic [1:0]       dig,
   input  logic [WIDTH-1:0] x_plus,
   input  logic [WIDTH-1:0] x_minus,
   output logic [WIDTH-1:0] p_plus,
   output logic [WIDTH-1:0] p_minus,
   output logic             ill
);

   always_comb begin
      p_plus  = '0;
      p_minus = '0;
      ill     = dig_is_ill(dig);
      case (dig)
         DIG_POS: begin
            p_plus  = x_plus;
            p_minus = x_minus;
         end
         DIG_NEG: begin
            // Rail swap is exact; complement keeps bit-compatibility with the old selector.
            if (NEG_MODE == NEG_CMPL) begin
               p_plus  = ~x_plus;
               p_minus = ~x_minus;
            end else begin
               p_plus  = x_minus;
               p_minus = x_plus;
            end
         end
         default: begin
            p_plus  = '0;
            p_minus = '0;
         end
      endcase
   end

endmodule

// File: rtl/sdvm_stream.sv
// Streaming signed-digit x vector multiplier: one registered product per accepted digit, 1-cycle latency.
// Backpressure: dig_ready = !out_valid | out_ready; output register holds while stalled.
module sdvm_stream
   import sdvm_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int NDIGITS  = 8,
   parameter int NEG_MODE = NEG_SWAP
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             vec_load,
   input  logic [WIDTH-1:0] vec_in_plus,
   input  logic [WIDTH-1:0] vec_in_minus,
   input  logic             dig_valid,
   output logic             dig_ready,
   input  logic [1:0]       dig_sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] vec_out_plus,
   output logic [WIDTH-1:0] vec_out_minus,
   output logic             out_last,
   output logic             busy,
   output logic             err,
   input  logic             err_clr
);

   localparam int CW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(NDIGITS - 1);

   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_nxt;
   logic [WIDTH-1:0] x_plus;
   logic [WIDTH-1:0] x_minus;
   logic [WIDTH-1:0] op_plus;
   logic [WIDTH-1:0] op_minus;
   logic [WIDTH-1:0] p_plus;
   logic [WIDTH-1:0] p_minus;
   logic             ill;
   logic             accept;
   logic             load_en;
   logic             at_last;

   assign dig_ready = !out_valid | out_ready;
   assign accept    = dig_valid & dig_ready;
   assign load_en   = vec_load & (cnt == '0);
   assign at_last   = (cnt == LAST_CNT);

   // A load coinciding with the first digit feeds the new operand straight through.
   assign op_plus  = load_en ? vec_in_plus  : x_plus;
   assign op_minus = load_en ? vec_in_minus : x_minus;

   always_comb begin
      cnt_nxt = cnt;
      if (accept) begin
         cnt_nxt = at_last ? '0 : cnt + CW'(1);
      end
   end

   sdvm_digit_mul #(
      .WIDTH    (WIDTH),
      .NEG_MODE (NEG_MODE)
   ) u_mul (
      .dig     (dig_sel),
      .x_plus  (op_plus),
      .x_minus (op_minus),
      .p_plus  (p_plus),
      .p_minus (p_minus),
      .ill     (ill)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_plus  <= '0;
         x_minus <= '0;
      end else if (load_en) begin
         x_plus  <= vec_in_plus;
         x_minus <= vec_in_minus;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt  <= '0;
         busy <= 1'b0;
      end else begin
         cnt  <= cnt_nxt;
         busy <= (cnt_nxt != '0);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid     <= 1'b0;
         vec_out_plus  <= '0;
         vec_out_minus <= '0;
         out_last      <= 1'b0;
      end else if (accept) begin
         out_valid     <= 1'b1;
         vec_out_plus  <= p_plus;
         vec_out_minus <= p_minus;
         out_last      <= at_last;
      end else if (out_ready) begin
         out_valid     <= 1'b0;
      end
   end

   // Set has priority over clear so a simultaneous illegal digit is never lost.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err <= 1'b0;
      end else if (accept & ill) begin
         err <= 1'b1;
      end else if (err_clr) begin
         err <= 1'b0;
      end
   end

endmodule
